// File: rtl/alu_issue_ctrl_pkg.sv
// Shared widths, ALU opcodes and issue-controller FSM states.
// No logic; types and defaults only.
// Imported by the controller, its register file and its interface.
package alu_issue_ctrl_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_NREGS  = 8;
    localparam int ALU_RET_W  = 16;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU, result and debug signals of the issue controller.
// Latency: none (wires only).
// Backpressure: instr_valid/instr_ready and res_valid/res_ready handshakes.
interface alu_issue_ctrl_if
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int RET_W  = ALU_RET_W
);
    localparam int AW = $clog2(NREGS);

    logic              instr_valid;
    logic              instr_ready;
    logic              instr_ld;
    logic [3:0]        instr_op;
    logic [AW-1:0]     instr_rd;
    logic [AW-1:0]     instr_rs1;
    logic [AW-1:0]     instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic [DATA_W-1:0] alu_reg_1;
    logic [DATA_W-1:0] alu_reg_2;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [AW-1:0]     res_rd;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [RET_W-1:0]  retired;

    // Environment side: instruction source, ALU and result consumer.
    modport master (
        output instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output alu_out, res_ready, dbg_addr,
        input  instr_ready, alu_reg_1, alu_reg_2, alu_op,
        input  res_valid, res_data, res_rd, dbg_data, retired
    );

    // Controller side.
    modport slave (
        input  instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  alu_out, res_ready, dbg_addr,
        output instr_ready, alu_reg_1, alu_reg_2, alu_op,
        output res_valid, res_data, res_rd, dbg_data, retired
    );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// NREGS x DATA_W register file: two operand read ports, one debug read port, one write port.
// Latency: reads combinational from the address; write lands on the rising edge.
// Backpressure: none; the caller qualifies wr_en.
module alu_issue_ctrl_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [AW-1:0]     rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // Single write port; every entry clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd1_data = mem[rd1_addr];
    assign rd2_data = mem[rd2_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external combinational ALU and writes results back.
// Latency: accept in cycle 0, res_valid from cycle 2, commit on the result handshake.
// Backpressure: instr_ready low from accept until commit; result held while res_ready is low.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int RET_W  = ALU_RET_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_ctrl_if.slave bus
);

    issue_state_e      state;
    logic              instr_ready_q;
    logic              ld_q;
    logic [3:0]        op_q;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] reg1_q;
    logic [DATA_W-1:0] reg2_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [AW-1:0]     res_rd_q;
    logic [RET_W-1:0]  retired_q;

    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic              accept;
    logic              commit;

    assign accept = bus.instr_valid && instr_ready_q;
    assign commit = res_valid_q && bus.res_ready;

    alu_issue_ctrl_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd1_addr (bus.instr_rs1),
        .rd1_data (rf_rd1),
        .rd2_addr (bus.instr_rs2),
        .rd2_data (rf_rd2),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data),
        .wr_en    (commit),
        .wr_addr  (res_rd_q),
        .wr_data  (res_data_q)
    );

    // Issue FSM with registered handshake outputs. Operand registers double as the ALU
    // drive, and loads leave them untouched, so the ALU inputs only move on entry to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            instr_ready_q <= 1'b0;
            ld_q          <= 1'b0;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            reg1_q        <= '0;
            reg2_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            retired_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    instr_ready_q <= 1'b1;
                    if (accept) begin
                        ld_q          <= bus.instr_ld;
                        rd_q          <= bus.instr_rd;
                        imm_q         <= bus.instr_imm;
                        if (!bus.instr_ld) begin
                            op_q   <= bus.instr_op;
                            reg1_q <= rf_rd1;
                            reg2_q <= rf_rd2;
                        end
                        instr_ready_q <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_data_q  <= ld_q ? imm_q : bus.alu_out;
                    res_rd_q    <= rd_q;
                    res_valid_q <= 1'b1;
                    state       <= WB;
                end
                WB: begin
                    if (bus.res_ready) begin
                        res_valid_q   <= 1'b0;
                        retired_q     <= retired_q + 1'b1;
                        instr_ready_q <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.alu_reg_1   = reg1_q;
    assign bus.alu_reg_2   = reg2_q;
    assign bus.alu_op      = op_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a stand-in combinational ALU.
// A queue/array reference model is compared against the DUT on every falling edge.
// Directed sequences add literal expectations that pin the model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int TB_RET_W = 8;

    logic clk;
    logic rst_n;

    alu_issue_ctrl_if #(.DATA_W(8), .NREGS(8), .RET_W(TB_RET_W)) bus ();

    alu_issue_ctrl #(.DATA_W(8), .NREGS(8), .RET_W(TB_RET_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // Stand-in ALU.
    always_comb bus.alu_out = alu_ref(bus.alu_op, bus.alu_reg_1, bus.alu_reg_2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dbg_pin = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    typedef struct {
        int data;
        int rd;
        int acc;
    } exp_t;
    exp_t q[$];
    logic [7:0] m_rf [8];
    int m_ret = 0;
    int m_a1 = 0;
    int m_a2 = 0;
    int m_op = 0;
    logic up;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) up <= 1'b0;
        else        up <= 1'b1;
    end

    // Compare process: check the DUT, then advance the model by the handshakes
    // that will fire on the coming rising edge.
    always @(negedge clk) begin : cmp
        bit exp_rdy;
        bit exp_rv;
        exp_t e;
        cyc = cyc + 1;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
            m_ret = 0;
            m_a1 = 0;
            m_a2 = 0;
            m_op = 0;
            chk("rst_instr_ready", int'(bus.instr_ready), 0);
            chk("rst_res_valid", int'(bus.res_valid), 0);
            chk("rst_retired", int'(bus.retired), 0);
        end else begin
            exp_rdy = up && (q.size() == 0);
            exp_rv  = (q.size() != 0) && (cyc >= q[0].acc + 2);
            chk("instr_ready", int'(bus.instr_ready), int'(exp_rdy));
            chk("res_valid", int'(bus.res_valid), int'(exp_rv));
            if (exp_rv) begin
                chk("res_data", int'(bus.res_data), q[0].data);
                chk("res_rd", int'(bus.res_rd), q[0].rd);
            end
            chk("alu_reg_1", int'(bus.alu_reg_1), m_a1);
            chk("alu_reg_2", int'(bus.alu_reg_2), m_a2);
            chk("alu_op", int'(bus.alu_op), m_op);
            chk("dbg_data", int'(bus.dbg_data), int'(m_rf[bus.dbg_addr]));
            chk("retired", int'(bus.retired), m_ret);
            if (exp_rv && bus.res_ready) begin
                m_rf[q[0].rd] = 8'(q[0].data);
                m_ret = (m_ret + 1) % (1 << TB_RET_W);
                void'(q.pop_front());
            end
            if (exp_rdy && bus.instr_valid) begin
                e.rd  = int'(bus.instr_rd);
                e.acc = cyc;
                if (bus.instr_ld) begin
                    e.data = int'(bus.instr_imm);
                end else begin
                    e.data = int'(alu_ref(bus.instr_op, m_rf[bus.instr_rs1], m_rf[bus.instr_rs2]));
                    m_a1 = int'(m_rf[bus.instr_rs1]);
                    m_a2 = int'(m_rf[bus.instr_rs2]);
                    m_op = int'(bus.instr_op);
                end
                q.push_back(e);
            end
        end
    end

    // Debug address sweeps continuously unless pinned by a peek.
    initial begin
        bus.dbg_addr = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            if (dbg_pin < 0) bus.dbg_addr = 3'(bus.dbg_addr + 3'd1);
            else             bus.dbg_addr = 3'(dbg_pin);
        end
    end

    task automatic send(input logic ld, input logic [3:0] op, input int rd, input int rs1,
                        input int rs2, input int imm);
        bit hs = 1'b0;
        int n = 0;
        bus.instr_ld    = ld;
        bus.instr_op    = op;
        bus.instr_rd    = 3'(rd);
        bus.instr_rs1   = 3'(rs1);
        bus.instr_rs2   = 3'(rs2);
        bus.instr_imm   = 8'(imm);
        bus.instr_valid = 1'b1;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = bus.instr_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.instr_valid = 1'b0;
        bus.instr_imm   = 8'hA5;
        bus.instr_rd    = 3'd7;
        if (!hs) chk("accept_timeout", 0, 1);
    endtask

    task automatic ld(input int rd, input int imm);
        send(1'b1, ALU_ADD, rd, 0, 0, imm);
    endtask

    task automatic op3(input logic [3:0] op, input int rd, input int rs1, input int rs2);
        send(1'b0, op, rd, rs1, rs2, 0);
    endtask

    task automatic wait_idle();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input string name, input int addr, input int exp);
        dbg_pin = addr;
        repeat (2) @(negedge clk);
        chk(name, int'(bus.dbg_data), exp);
        dbg_pin = -1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_ld    = 1'b0;
        bus.instr_op    = 4'h0;
        bus.instr_rd    = 3'd0;
        bus.instr_rs1   = 3'd0;
        bus.instr_rs2   = 3'd0;
        bus.instr_imm   = 8'h00;
        bus.res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end

        // Reset state: every register reads zero.
        for (int i = 0; i < 8; i++) peek("t1_reg_zero", i, 0);
        chk("t1_retired", int'(bus.retired), 0);

        // Loads then an add that wraps: 200 + 100 = 300 mod 256 = 44.
        ld(1, 200);
        ld(2, 100);
        op3(ALU_ADD, 3, 1, 2);
        wait_idle();
        peek("t2_r3", 3, 44);
        chk("t2_retired", int'(bus.retired), 3);

        // Backpressure in WB for 5 cycles, with a stray instr_valid pulse that must be ignored.
        op3(ALU_ADD, 3, 2, 2);
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus.instr_ld = 1'b1;
                bus.instr_rd = 3'd3;
                bus.instr_imm = 8'hEE;
                bus.instr_valid = 1'b1;
            end
            if (i == 3) bus.instr_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("t3_stall_res_valid", int'(bus.res_valid), 1);
        chk("t3_stall_res_data", int'(bus.res_data), 200);
        bus.res_ready = 1'b1;
        wait_idle();
        peek("t3_r3", 3, 200);
        chk("t3_retired", int'(bus.retired), 4);

        // Back-to-back dependent adds see the written-back value.
        ld(1, 7);
        op3(ALU_ADD, 1, 1, 1);
        op3(ALU_ADD, 2, 1, 1);
        wait_idle();
        peek("t4_r1", 1, 14);
        peek("t4_r2", 2, 28);

        // Subtract wraps: 5 - 9 = 252.
        ld(1, 5);
        ld(2, 9);
        op3(ALU_SUB, 6, 1, 2);
        wait_idle();
        peek("t4_sub_r6", 6, 252);

        // Reset asserted while an add is in ISSUE: nothing is written back.
        op3(ALU_ADD, 5, 1, 2);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle();
        peek("t5_r5", 5, 0);
        peek("t5_r1", 1, 0);
        peek("t5_r6", 6, 0);
        chk("t5_retired", int'(bus.retired), 0);

        // Boundary sums.
        ld(1, 255);
        ld(2, 1);
        op3(ALU_ADD, 4, 1, 2);
        ld(2, 255);
        op3(ALU_ADD, 7, 1, 2);
        wait_idle();
        peek("t6_255p1", 4, 0);
        peek("t6_255p255", 7, 254);

        // Operand sweep; retired wraps several times at the bench counter width.
        begin
            int k = 0;
            for (int a = 0; a < 256; a += 17) begin
                for (int b = 0; b < 256; b += 15) begin
                    ld(1, a);
                    ld(2, (b == 255) ? 255 : b);
                    op3(ALU_ADD, 3 + (k % 5), 1, 2);
                    k++;
                end
                ld(1, a);
                ld(2, 255);
                op3(ALU_ADD, 3, 1, 2);
            end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
